wr_ptr_full_ctrl: RTL and testbench
===================================

# wr_ptr_full_ctrl

Write-side pointer and flag controller for the asynchronous FIFO, the write-domain counterpart of the read pointer block. It keeps the binary and Gray write pointers and supplies the memory write address. It generates registered full, almost-full and fill-level status by comparing against the read Gray pointer, which has already been synchronized into the write clock domain. A sticky overflow flag and a write acknowledge support upstream flow control and debug.

## Interface
Parameters:
- ptr_size, 4: address width; FIFO depth = 2^ptr_size; pointers are ptr_size+1 bits wide; legal values are ≥ 2.
- AF_THRESH, 12: almost_full asserts when the fill level is ≥ AF_THRESH; legal range 1 … 2^ptr_size.

Ports:
- wr_clk, input, 1: write-domain clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- wr_en, input, 1: write request.
- clr_ovf, input, 1: synchronous clear of overflow.
- g_rd_ptr_sync, input, ptr_size+1: read Gray pointer after the 2-flop synchronizer.
- wr_addr, output, ptr_size: memory write address, equal to b_wr_ptr[ptr_size-1:0] (combinational from the register).
- b_wr_ptr, output reg, ptr_size+1: binary write pointer.
- g_wr_ptr, output reg, ptr_size+1: Gray write pointer, sent to the read-domain synchronizer.
- full, output reg, 1: FIFO full.
- almost_full, output reg, 1: fill level ≥ AF_THRESH.
- wr_level, output reg, ptr_size+1: fill level as seen from the write side, range 0 … 2^ptr_size.
- wr_ack, output reg, 1: one-cycle pulse, the cycle after each accepted write.
- overflow, output reg, 1: sticky flag, set when a write is attempted while full.

## Operation
- Write acceptance: accept = wr_en & ~full, using the registered full.
  - The memory writes at wr_addr whenever accept = 1.
- Binary pointer: b_wr_ptr_next = b_wr_ptr + accept, modulo 2^(ptr_size+1).
- Gray pointer: g_wr_ptr_next = (b_wr_ptr_next >> 1) ^ b_wr_ptr_next.
  - g_wr_ptr changes by exactly 1 bit per accepted write, and never changes without an accept.
- Full:
  - full_next = (g_wr_ptr_next == {~g_rd_ptr_sync[ptr_size:ptr_size-1], g_rd_ptr_sync[ptr_size-2:0]}).
- Read pointer conversion: b_rd_sync is the Gray-to-binary conversion of g_rd_ptr_sync.
  - b_rd_sync[ptr_size] = g_rd_ptr_sync[ptr_size].
  - b_rd_sync[i] = b_rd_sync[i+1] ^ g_rd_ptr_sync[i].
- Level: level_next = b_wr_ptr_next − b_rd_sync, computed modulo 2^(ptr_size+1).
  - The result never exceeds 2^ptr_size while the synchronizer is consistent.
- Almost-full: almost_full_next = (level_next ≥ AF_THRESH).
- Register updates on every edge: b_wr_ptr, g_wr_ptr, full, wr_level and almost_full load their _next values; wr_ack loads accept.
- Overflow priority: set if (wr_en & full); else cleared if clr_ovf; else hold.
  - When set and clear coincide, set wins.
- Full behaviour: writes while full are dropped.
  - Pointers, wr_level and wr_ack stay unchanged; only overflow reacts.
- Wrap-around: the pointer rolls over from 2^(ptr_size+1)−1 to 0.
  - The Gray code and full comparison stay valid across the rollover, with no special-casing.
- Reset values (rst_n low, asynchronous): b_wr_ptr=0, g_wr_ptr=0, full=0, almost_full=0, wr_level=0, wr_ack=0, overflow=0, so wr_addr=0.
  - Reset mid-operation aborts any in-flight write.
  - The first edge after rst_n deasserts behaves as the first write from empty.

## Timing
- Write latency: a write accepted at edge N updates b_wr_ptr, g_wr_ptr and wr_level at edge N.
  - wr_ack is high for the cycle following edge N.
- Full assertion: full asserts at the same edge as the write that fills the FIFO, so a back-to-back wr_en on the next cycle is already blocked.
- Full deassertion: full drops at the first edge after g_rd_ptr_sync shows a read.
  - This is one write-clock cycle after the synchronizer output changes; it is pessimistic, never optimistic.
- wr_level and almost_full follow the same one-edge registration; they may lag the true level by the synchronizer delay.
- Simultaneous accepted write and read-pointer advance in the same cycle: level_next is unchanged.
- Throughput: one write per cycle is sustained while not full.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle -> every output is 0 immediately; release, then a single write -> b_wr_ptr=1, g_wr_ptr=00001, wr_ack pulses once.
- Fill: ptr_size=4, g_rd_ptr_sync=0, 16 consecutive writes -> full=1 at the 16th edge; b_wr_ptr=10000, g_wr_ptr=11000, wr_level=16; almost_full=1 from the 12th edge on.
- Overflow: while full, wr_en=1 for 3 cycles -> pointers unchanged, wr_ack=0, overflow=1. clr_ovf together with wr_en -> overflow stays 1; clr_ovf alone -> overflow=0.
- Drain release: with the FIFO full, step g_rd_ptr_sync to 00001 -> full=0 and wr_level=15 on the next edge; the following write refills -> full=1.
- Wrap: 40 writes interleaved with read-pointer advances that keep the level ≤ 8 -> b_wr_ptr rolls over 31→0; every g_wr_ptr step changes exactly 1 bit; full is never asserted; wr_level matches the reference model each cycle.
- Reset mid-operation: at level 10, assert rst_n=0 -> all outputs return to 0 and the next write starts at wr_addr=0.

Source files
------------

// File: rtl/wr_ptr_full_ctrl_if.sv
// Write-side FIFO control bundle: write request/clear in, pointers and status out.
// The controller side is 'slave'; the upstream writer (or bench) side is 'master'.
interface wr_ptr_full_ctrl_if #(
  parameter int ptr_size = 4
);
  logic                wr_en;
  logic                clr_ovf;
  logic [ptr_size:0]   g_rd_ptr_sync;
  logic [ptr_size-1:0] wr_addr;
  logic [ptr_size:0]   b_wr_ptr;
  logic [ptr_size:0]   g_wr_ptr;
  logic                full;
  logic                almost_full;
  logic [ptr_size:0]   wr_level;
  logic                wr_ack;
  logic                overflow;

  modport slave (
    input  wr_en, clr_ovf, g_rd_ptr_sync,
    output wr_addr, b_wr_ptr, g_wr_ptr, full, almost_full, wr_level, wr_ack, overflow
  );

  modport master (
    output wr_en, clr_ovf, g_rd_ptr_sync,
    input  wr_addr, b_wr_ptr, g_wr_ptr, full, almost_full, wr_level, wr_ack, overflow
  );
endinterface

// File: rtl/wr_ptr_full_ctrl.sv
// Async-FIFO write pointer/flag controller; pointers, flags and level update on the accepting edge, wr_ack one cycle later.
// Writes while full are dropped (no pointer movement) and latch the sticky overflow flag.
module wr_ptr_full_ctrl #(
  parameter int ptr_size  = 4,
  parameter int AF_THRESH = 12
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  wr_ptr_full_ctrl_if.slave     bus
);
  localparam int W = ptr_size + 1;

  logic [W-1:0] b_wr_ptr_q, b_wr_ptr_d;
  logic [W-1:0] g_wr_ptr_q, g_wr_ptr_d;
  logic [W-1:0] level_q,    level_d;
  logic         full_q,     full_d;
  logic         af_q,       af_d;
  logic         ack_q;
  logic         ovf_q,      ovf_d;

  logic         accept;
  logic [W-1:0] b_rd_sync;
  logic [W-1:0] full_pattern;

  assign accept = bus.wr_en & ~full_q;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b_rd_sync = '0;
    for (int i = 0; i < W; i++) begin
      b_rd_sync[i] = ^(bus.g_rd_ptr_sync >> i);
    end
  end

  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign full_pattern = {~bus.g_rd_ptr_sync[ptr_size:ptr_size-1],
                         bus.g_rd_ptr_sync[ptr_size-2:0]};

  always_comb begin
    b_wr_ptr_d = b_wr_ptr_q + W'(accept);
    g_wr_ptr_d = (b_wr_ptr_d >> 1) ^ b_wr_ptr_d;
    full_d     = (g_wr_ptr_d == full_pattern);
    level_d    = b_wr_ptr_d - b_rd_sync;
    af_d       = (level_d >= W'(AF_THRESH));
    ovf_d      = ovf_q;
    if (bus.wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      b_wr_ptr_q <= '0;
      g_wr_ptr_q <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      af_q       <= 1'b0;
      ack_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      b_wr_ptr_q <= b_wr_ptr_d;
      g_wr_ptr_q <= g_wr_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      af_q       <= af_d;
      ack_q      <= accept;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.wr_addr     = b_wr_ptr_q[ptr_size-1:0];
  assign bus.b_wr_ptr    = b_wr_ptr_q;
  assign bus.g_wr_ptr    = g_wr_ptr_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.wr_level    = level_q;
  assign bus.wr_ack      = ack_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_wr_ptr_full_ctrl.sv
// Bench for wr_ptr_full_ctrl: write/read counters model the FIFO occupancy directly,
// directed scenarios pin literal values, random phases compare every cycle.
module tb_wr_ptr_full_ctrl;
  localparam int PS    = 4;
  localparam int AF    = 12;
  localparam int DEPTH = 1 << PS;
  localparam int MODV  = 2 * DEPTH;

  logic wr_clk = 1'b0;
  logic rst_n  = 1'b0;

  wr_ptr_full_ctrl_if #(.ptr_size(PS)) bus ();

  wr_ptr_full_ctrl #(.ptr_size(PS), .AF_THRESH(AF)) dut (
    .wr_clk (wr_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 wr_clk = ~wr_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: write count and read count, both modulo 2*DEPTH; occupancy is their difference.
  int m_w   = 0;
  int m_r   = 0;
  int m_lvl = 0;
  bit m_full = 1'b0;
  bit m_af   = 1'b0;
  bit m_ack  = 1'b0;
  bit m_ovf  = 1'b0;

  function automatic int gray(input int v);
    return (v ^ (v >> 1)) & (MODV - 1);
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge wr_clk) begin
    if (rst_n) begin
      check("b_wr_ptr",    int'(bus.b_wr_ptr),    m_w);
      check("g_wr_ptr",    int'(bus.g_wr_ptr),    gray(m_w));
      check("wr_addr",     int'(bus.wr_addr),     m_w % DEPTH);
      check("wr_level",    int'(bus.wr_level),    m_lvl);
      check("full",        int'(bus.full),        int'(m_full));
      check("almost_full", int'(bus.almost_full), int'(m_af));
      check("wr_ack",      int'(bus.wr_ack),      int'(m_ack));
      check("overflow",    int'(bus.overflow),    int'(m_ovf));
    end
  end

  // One clock: drive inputs, advance the model, return at posedge+1.
  task automatic step(input bit wr, input bit clr, input bit radv);
    bit acc;
    int g_before;
    if (radv) m_r = (m_r + 1) % MODV;
    bus.wr_en         = wr;
    bus.clr_ovf       = clr;
    bus.g_rd_ptr_sync = (PS+1)'(gray(m_r));
    g_before = int'(bus.g_wr_ptr);
    acc = wr && !m_full;
    @(posedge wr_clk);
    #1;
    if (wr && m_full)  m_ovf = 1'b1;
    else if (clr)      m_ovf = 1'b0;
    m_w    = (m_w + int'(acc)) % MODV;
    m_lvl  = (m_w - m_r + MODV) % MODV;
    m_full = (m_lvl == DEPTH);
    m_af   = (m_lvl >= AF);
    m_ack  = acc;
    check("g_one_bit_step", $countones(int'(bus.g_wr_ptr) ^ g_before), int'(acc));
  endtask

  task automatic model_zero();
    m_w = 0; m_r = 0; m_lvl = 0;
    m_full = 0; m_af = 0; m_ack = 0; m_ovf = 0;
  endtask

  // Called at posedge+1: assert reset mid-cycle, verify outputs clear at once, release mid-cycle.
  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_b_wr_ptr", int'(bus.b_wr_ptr),    0);
    check("rst_g_wr_ptr", int'(bus.g_wr_ptr),    0);
    check("rst_wr_addr",  int'(bus.wr_addr),     0);
    check("rst_level",    int'(bus.wr_level),    0);
    check("rst_full",     int'(bus.full),        0);
    check("rst_af",       int'(bus.almost_full), 0);
    check("rst_ack",      int'(bus.wr_ack),      0);
    check("rst_ovf",      int'(bus.overflow),    0);
    model_zero();
    bus.wr_en         = 1'b0;
    bus.clr_ovf       = 1'b0;
    bus.g_rd_ptr_sync = '0;
    @(posedge wr_clk);
    @(posedge wr_clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit wrapped, saw_full;
    int prev_b, writes;
    bus.wr_en         = 1'b0;
    bus.clr_ovf       = 1'b0;
    bus.g_rd_ptr_sync = '0;
    repeat (2) @(posedge wr_clk);
    #1;
    rst_n = 1'b1;

    // Dirty the state, then reset mid-cycle and do a single write.
    repeat (3) step(1, 0, 0);
    reset_mid();
    step(1, 0, 0);
    check("first_b", int'(bus.b_wr_ptr), 1);
    check("first_g", int'(bus.g_wr_ptr), 5'b00001);
    check("first_ack", int'(bus.wr_ack), 1);
    step(0, 0, 0);
    check("first_ack_drop", int'(bus.wr_ack), 0);

    // Fill from empty.
    reset_mid();
    for (int k = 1; k <= DEPTH; k++) begin
      step(1, 0, 0);
      if (k == 11) check("fill_af_11", int'(bus.almost_full), 0);
      if (k == 12) check("fill_af_12", int'(bus.almost_full), 1);
      if (k == 15) check("fill_full_15", int'(bus.full), 0);
    end
    check("fill_full",  int'(bus.full),     1);
    check("fill_b",     int'(bus.b_wr_ptr), 5'b10000);
    check("fill_g",     int'(bus.g_wr_ptr), 5'b11000);
    check("fill_level", int'(bus.wr_level), 16);

    // Overflow while full.
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      check("ovf_b",   int'(bus.b_wr_ptr), 16);
      check("ovf_ack", int'(bus.wr_ack),   0);
      check("ovf_set", int'(bus.overflow), 1);
    end
    step(1, 1, 0);
    check("ovf_set_wins", int'(bus.overflow), 1);
    step(0, 1, 0);
    check("ovf_cleared", int'(bus.overflow), 0);

    // Drain release and refill.
    step(0, 0, 1);
    check("drain_full",  int'(bus.full),     0);
    check("drain_level", int'(bus.wr_level), 15);
    step(1, 0, 0);
    check("refill_full", int'(bus.full),     1);

    // Wrap with level kept at or below 8.
    reset_mid();
    wrapped = 0; saw_full = 0; writes = 0;
    prev_b = 0;
    for (int c = 0; c < 600 && !(wrapped && writes >= 40); c++) begin
      bit wr, radv;
      wr   = (m_lvl < 8) && ($urandom_range(3) != 0);
      radv = (m_r != m_w) && ($urandom_range(1) != 0);
      step(wr, 0, radv);
      if (wr) writes++;
      if (prev_b == MODV - 1 && int'(bus.b_wr_ptr) == 0) wrapped = 1;
      if (bus.full) saw_full = 1;
      prev_b = int'(bus.b_wr_ptr);
    end
    check("wrap_rollover", int'(wrapped),  1);
    check("wrap_no_full",  int'(saw_full), 0);
    check("wrap_writes_ge_40", int'(writes >= 40), 1);

    // Random traffic with frequent full and overflow episodes.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(3) != 0, $urandom_range(7) == 0,
           (m_r != m_w) && ($urandom_range(2) == 0));
    end

    // Reset mid-operation at level 10.
    reset_mid();
    repeat (10) step(1, 0, 0);
    check("mid_level", int'(bus.wr_level), 10);
    reset_mid();
    check("post_rst_addr", int'(bus.wr_addr), 0);
    step(1, 0, 0);
    check("post_rst_b",   int'(bus.b_wr_ptr), 1);
    check("post_rst_ack", int'(bus.wr_ack),   1);
    step(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
